user_obi_mgr_arb: RTL
=====================

# user_obi_mgr_arb

Parametrised N-to-1 OBI manager arbiter for the user domain. It merges NumMgr user manager ports (DMA engines, accelerators) onto the single user manager port toward the Croc subordinates, and selects between round-robin and fixed-priority arbitration. It tracks outstanding transactions in an in-order ID FIFO so that each response returns to its issuing manager. It holds the A-channel selection stable until grant and flags protocol errors.

## Interface
Parameters:
- NumMgr, 2, number of upstream manager ports (≥1; 1 degenerates to pass-through with tracking).
- NumMaxTrans, 4, max outstanding transactions; power of two, ≥1.
- ArbMode, 0, 0 = round-robin, 1 = fixed priority (index 0 highest).
- AddrWidth, 32, address width.
- DataWidth, 32, data width; byte enable is DataWidth/8.

Ports:
- clk_i  in  1  clock, all logic rising-edge.
- rst_i  in  1  reset, synchronous, active-high.
- sbr_req_i  in  NumMgr  per-manager A-channel request.
- sbr_gnt_o  out  NumMgr  per-manager grant.
- sbr_addr_i  in  NumMgr×AddrWidth  addresses.
- sbr_we_i  in  NumMgr  write enable.
- sbr_be_i  in  NumMgr×DataWidth/8  byte enables.
- sbr_wdata_i  in  NumMgr×DataWidth  write data.
- sbr_rvalid_o  out  NumMgr  per-manager response valid.
- sbr_rdata_o  out  DataWidth  response data, broadcast to all ports; qualified by sbr_rvalid_o.
- sbr_err_o  out  1  response error, broadcast; qualified by sbr_rvalid_o.
- mgr_req_o / mgr_gnt_i  out/in  1  downstream A-channel handshake.
- mgr_addr_o, mgr_we_o, mgr_be_o, mgr_wdata_o  out  as above  forwarded A-channel.
- mgr_rvalid_i, mgr_rdata_i, mgr_err_i  in  1/DataWidth/1  downstream response.
- outstanding_o  out  clog2(NumMaxTrans+1)  current FIFO occupancy.
- proto_err_o  out  1  sticky: mgr_rvalid_i seen with no outstanding transaction.

## Operation
- Arbitration takes place only when no request is locked.
  - ArbMode 0: the winner is the first requester at or after rr_ptr, searching cyclically.
  - ArbMode 1: the winner is the lowest-index requester.
- Lock: when mgr_req_o is high and mgr_gnt_i is low, the selected index is registered, and the next cycle reuses it regardless of other requests (OBI stability). The lock clears on handshake.
- mgr_req_o = winner requesting AND FIFO not full. mgr_* A fields are muxed from the winner. Outputs are 0 when no request is made.
- sbr_gnt_o[w] = mgr_gnt_i AND mgr_req_o, for the winner only.
- On handshake (mgr_req_o & mgr_gnt_i):
  - push the winner index into the FIFO;
  - in ArbMode 0, set rr_ptr = (winner+1) mod NumMgr.
- On mgr_rvalid_i with the FIFO non-empty:
  - pop the head;
  - drive sbr_rvalid_o[head] = 1 combinationally;
  - pass rdata/err through.
- On mgr_rvalid_i with the FIFO empty: set proto_err_o; no sbr_rvalid_o is driven; the FIFO is unchanged.
- When the FIFO is full, mgr_req_o is forced low even if a pop occurs that cycle. This avoids a gnt→rvalid combinational dependency.
- A simultaneous push and pop when the FIFO is not full leaves occupancy unchanged and keeps order.
- A withdrawn upstream request while locked is a protocol violation. The lock still holds, and mgr_req_o follows sbr_req_i[locked].

## Timing
- A-channel: zero-cycle combinational path req→req and gnt→gnt.
- Response: zero-cycle path rvalid→rvalid; rdata is not registered.
- FIFO push/pop and occupancy update at the clock edge after the handshake or response. outstanding_o is registered.
- Reset (rst_i high at the edge):
  - FIFO is emptied; outstanding_o = 0;
  - rr_ptr = 0; lock cleared; proto_err_o = 0.
  - While rst_i is high, all sbr_gnt_o, sbr_rvalid_o and mgr_req_o are forced 0.
- Reset mid-transaction drops the tracking state. Responses arriving after reset raise proto_err_o.
- FIFO pointers wrap modulo NumMaxTrans. Occupancy counts 0..NumMaxTrans inclusive.

## Structure
- The shared user_pkg holds:
  - the ArbMode encoding constants (ArbRoundRobin = 0, ArbFixedPrio = 1);
  - the NumUserMgr default.
- Sub-module user_obi_id_fifo: parametrised depth/width, synchronous active-high reset, push/pop/full/empty/count.
- The arbiter logic (rr_ptr, lock, winner select) stays in the top.

## Test plan
- Round-robin fairness:
  - Setup: NumMgr=3, all requesting continuously, mgr_gnt_i=1, responses 1 cycle later.
  - Required: grants in order 0,1,2,0,1,2; each sbr_rvalid_o goes to the matching index.
- Fixed priority: ArbMode=1, managers 0 and 2 requesting → manager 0 is granted every cycle; manager 2 is granted only when sbr_req_i[0] drops.
- Lock stability: mgr_gnt_i low for 3 cycles while manager 1 holds its request and manager 0 raises its request → mgr_addr_o stays at manager 1's address; manager 1 is granted on the 4th cycle.
- Full backpressure:
  - Setup: NumMaxTrans=4, 4 handshakes with no responses.
  - Required: outstanding_o = 4 and mgr_req_o = 0; a response pops the FIFO, and the next cycle mgr_req_o returns high.
- Out-of-order arrival of request sources:
  - Setup: handshakes issued from managers 2,0,1; responses with rdata 0xA, 0xB, 0xC.
  - Required: sbr_rvalid_o pulses at indices 2,0,1 in that order; err is passed through.
- Protocol error and reset:
  - Stimulus: mgr_rvalid_i asserted with an empty FIFO → proto_err_o goes to 1 and stays set.
  - Stimulus: rst_i asserted mid-transaction → all state clears; a stale response raises proto_err_o again.

Source files
------------

// File: rtl/user_pkg.sv
// Shared user-domain constants: arbitration mode encodings and manager-count defaults.
package user_pkg;

    localparam int unsigned ArbRoundRobin = 0;
    localparam int unsigned ArbFixedPrio  = 1;

    localparam int unsigned NumUserMgr = 2;

    // Index width that stays at least one bit wide for single-entry ranges.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/user_obi_id_fifo.sv
// In-order ID FIFO recording which manager issued each outstanding transaction.
module user_obi_id_fifo
    import user_pkg::*;
#(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 1,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned PtrW = idx_width(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload needs no reset: it is only read while the FIFO is non-empty.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/user_obi_mgr_arb.sv
// N-to-1 OBI manager arbiter with A-channel locking and in-order response routing.
module user_obi_mgr_arb
    import user_pkg::*;
#(
    parameter int unsigned NumMgr      = NumUserMgr,
    parameter int unsigned NumMaxTrans = 4,
    parameter int unsigned ArbMode     = ArbRoundRobin,
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned DataWidth   = 32,
    localparam int unsigned BeWidth    = DataWidth / 8,
    localparam int unsigned CntW       = $clog2(NumMaxTrans + 1)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NumMgr-1:0]                  sbr_req_i,
    output logic [NumMgr-1:0]                  sbr_gnt_o,
    input  logic [NumMgr-1:0][AddrWidth-1:0]   sbr_addr_i,
    input  logic [NumMgr-1:0]                  sbr_we_i,
    input  logic [NumMgr-1:0][BeWidth-1:0]     sbr_be_i,
    input  logic [NumMgr-1:0][DataWidth-1:0]   sbr_wdata_i,
    output logic [NumMgr-1:0]                  sbr_rvalid_o,
    output logic [DataWidth-1:0]               sbr_rdata_o,
    output logic                               sbr_err_o,
    output logic                               mgr_req_o,
    input  logic                               mgr_gnt_i,
    output logic [AddrWidth-1:0]               mgr_addr_o,
    output logic                               mgr_we_o,
    output logic [BeWidth-1:0]                 mgr_be_o,
    output logic [DataWidth-1:0]               mgr_wdata_o,
    input  logic                               mgr_rvalid_i,
    input  logic [DataWidth-1:0]               mgr_rdata_i,
    input  logic                               mgr_err_i,
    output logic [CntW-1:0]                    outstanding_o,
    output logic                               proto_err_o
);

    localparam int unsigned IdxW = idx_width(NumMgr);

    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic            lock_q, lock_d;
    logic            proto_err_q, proto_err_d;

    logic [IdxW-1:0] arb_idx, winner, fifo_head;
    logic            arb_found, win_req, handshake, rsp_pop;
    logic            fifo_full, fifo_empty;
    int unsigned     cand;

    always_comb begin
        arb_idx   = '0;
        arb_found = 1'b0;
        cand      = 0;
        if (ArbMode == ArbFixedPrio) begin
            // Scan downward so the lowest requesting index is assigned last.
            for (int i = int'(NumMgr) - 1; i >= 0; i--) begin
                if (sbr_req_i[IdxW'(i)]) begin
                    arb_idx   = IdxW'(i);
                    arb_found = 1'b1;
                end
            end
        end else begin
            for (int unsigned i = 0; i < NumMgr; i++) begin
                cand = (int'(rr_ptr_q) + i) % NumMgr;
                if (!arb_found && sbr_req_i[IdxW'(cand)]) begin
                    arb_idx   = IdxW'(cand);
                    arb_found = 1'b1;
                end
            end
        end
    end

    assign winner    = lock_q ? lock_idx_q : arb_idx;
    assign win_req   = sbr_req_i[winner];
    // Full blocks requests even when a pop is due this cycle: no gnt->rvalid comb path.
    assign mgr_req_o = !rst_i && win_req && !fifo_full;
    assign handshake = mgr_req_o && mgr_gnt_i;
    assign rsp_pop   = !rst_i && mgr_rvalid_i && !fifo_empty;

    assign mgr_addr_o  = mgr_req_o ? sbr_addr_i[winner]  : '0;
    assign mgr_we_o    = mgr_req_o ? sbr_we_i[winner]    : 1'b0;
    assign mgr_be_o    = mgr_req_o ? sbr_be_i[winner]    : '0;
    assign mgr_wdata_o = mgr_req_o ? sbr_wdata_i[winner] : '0;

    assign sbr_rdata_o = mgr_rdata_i;
    assign sbr_err_o   = mgr_err_i;
    assign proto_err_o = proto_err_q;

    always_comb begin
        sbr_gnt_o    = '0;
        sbr_rvalid_o = '0;
        rr_ptr_d     = rr_ptr_q;
        lock_d       = lock_q;
        lock_idx_d   = lock_idx_q;
        proto_err_d  = proto_err_q | (mgr_rvalid_i & fifo_empty);
        if (handshake) begin
            sbr_gnt_o[winner] = 1'b1;
            lock_d            = 1'b0;
            if (ArbMode == ArbRoundRobin) begin
                rr_ptr_d = (winner == IdxW'(NumMgr - 1)) ? '0 : winner + IdxW'(1);
            end
        end else if (mgr_req_o) begin
            lock_d     = 1'b1;
            lock_idx_d = winner;
        end
        if (rsp_pop) begin
            sbr_rvalid_o[fifo_head] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q    <= '0;
            lock_q      <= 1'b0;
            lock_idx_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            lock_q      <= lock_d;
            lock_idx_q  <= lock_idx_d;
            proto_err_q <= proto_err_d;
        end
    end

    user_obi_id_fifo #(
        .Depth (NumMaxTrans),
        .Width (IdxW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (handshake),
        .data_i  (winner),
        .pop_i   (rsp_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstanding_o)
    );

endmodule
